// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built from a single 4-bit adder slice.
// Operands are latched on an accepted start. One nibble is added per clock,
// LSB nibble first, with the nibble carry registered between steps.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding nibble idx (0..N-1), busy high
// DONE  | one-cycle result strobe; start here chains straight into RUN
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, sum_upd;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib;
  logic             accept, last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Nibble slice: select the current operand nibbles and add with the chained carry
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    sum_upd = sum;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    {c_nib, s_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) sum_upd[4*i +: 4] = s_nib;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start while RUN is dropped, not queued
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch and per-nibble accumulation; results hold until next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == RUN) begin
      sum     <= sum_upd;
      carry_q <= c_nib;
      idx     <= idx + 1'b1;
      if (last) begin
        cout <= c_nib;
        // carry into the MSB is a^b^s at that bit; XOR with carry out gives overflow
        ovf  <= a_nib[3] ^ b_nib[3] ^ s_nib[3] ^ c_nib;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table plus
// hand-written start-collision, back-to-back and mid-run reset sequences.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after the sampling edge; returns at the negedge where done is seen
  task automatic wait_done(output int bc, output bit got);
    bc  = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_op(input string name, input vec_t v);
    int bc;
    bit got;
    launch(v.a, v.b, v.cin);
    wait_done(bc, got);
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " busy_cycles"}, 32'(bc), 32'(N));
    check({name, " sum"}, 32'(sum), 32'(v.exp_sum));
    check({name, " cout"}, 32'(cout), 32'(v.exp_cout));
    check({name, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
    @(negedge clk);
    check({name, " done_fall"}, 32'(done), 32'd0);
    check({name, " idle_busy"}, 32'(busy), 32'd0);
    check({name, " sum_hold"}, 32'(sum), 32'(v.exp_sum));
  endtask

  initial begin
    int bc;
    bit got;
    bit saw_done;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // Operand isolation: change a/b/cin after edge 2
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    a   = 16'h0000;
    b   = 16'h0000;
    cin = 1'b0;
    wait_done(bc, got);
    check("iso done_seen", 32'(got), 32'd1);
    check("iso sum", 32'(sum), 32'h0000FFFF);
    check("iso cout", 32'(cout), 32'd1);
    check("iso ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // start re-pulsed during RUN is ignored and not queued
    launch(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #1;
    a     = 16'h0001;
    b     = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(bc, got);
    check("ign done_seen", 32'(got), 32'd1);
    check("ign sum", 32'(sum), 32'h00005555);
    check("ign cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("ign not_queued", 32'(busy), 32'd0);
    @(negedge clk);

    // Back-to-back: start held during the DONE cycle
    launch(16'h1234, 16'h4321, 1'b0);
    wait_done(bc, got);
    check("b2b first_done", 32'(got), 32'd1);
    check("b2b first_sum", 32'(sum), 32'h00005555);
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b done_fall", 32'(done), 32'd0);
    check("b2b busy_rise", 32'(busy), 32'd1);
    wait_done(bc, got);
    check("b2b second_done", 32'(got), 32'd1);
    check("b2b second_sum", 32'(sum), 32'h00000100);
    check("b2b second_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    launch(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    check("mrst sum", 32'(sum), 32'd0);
    check("mrst cout", 32'(cout), 32'd0);
    check("mrst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("mrst no_done", 32'(saw_done), 32'd0);
    do_op("mrst restart", '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
